// File: rtl/vx_cache_evict_buffer.sv
// Write-back eviction buffer: captures dirty evicted lines, merges repeat
// evictions of the same line into the pending entry, drops clean lines,
// and drains entries in FIFO order as masked line writes to memory.
module vx_cache_evict_buffer #(
    parameter int LINE_SIZE       = 16,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int DEPTH           = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         evict_valid,
    output logic                         evict_ready,
    input  logic [LINE_ADDR_WIDTH-1:0]   evict_addr,
    input  logic [LINE_SIZE*8-1:0]       evict_data,
    input  logic [LINE_SIZE-1:0]         evict_byteen,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [LINE_ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [LINE_SIZE*8-1:0]       mem_req_data,
    output logic [LINE_SIZE-1:0]         mem_req_byteen,
    input  logic [LINE_ADDR_WIDTH-1:0]   lookup_addr,
    output logic                         lookup_hit,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int DATA_W = LINE_SIZE * 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]           valid_q;
    logic [LINE_ADDR_WIDTH-1:0] addr_q   [DEPTH];
    logic [DATA_W-1:0]          data_q   [DEPTH];
    logic [LINE_SIZE-1:0]       byteen_q [DEPTH];
    logic [PTR_W-1:0]           head_q;
    logic [PTR_W-1:0]           tail_q;
    logic [CNT_W-1:0]           count_q;

    logic             merge_hit;
    logic [PTR_W-1:0] merge_idx;
    logic             is_clean;
    logic             is_full;
    logic             is_empty;
    logic             do_enq;
    logic             do_merge;
    logic             do_deq;

    // Find a non-head entry holding the evicted line; the head may be leaving
    // this cycle, so it is never a merge target.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == evict_addr)) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(i);
            end
        end
    end

    // Probe from the bank fill path: any valid entry, head included.
    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == lookup_addr)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    assign is_clean = (evict_byteen == '0);
    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Ready never looks at mem_req_ready: a slot freed by a same-cycle
    // dequeue cannot be reused while full.
    assign evict_ready = ~is_full | merge_hit | is_clean;

    assign do_enq   = evict_valid & ~is_clean & ~merge_hit & ~is_full;
    assign do_merge = evict_valid & ~is_clean & merge_hit;
    assign do_deq   = ~is_empty & mem_req_ready;

    // Request port is a pure function of registered state; zeroed when idle
    // so unreset storage never shows up on the outputs.
    assign mem_req_valid  = ~is_empty;
    assign mem_req_addr   = is_empty ? '0 : addr_q[head_q];
    assign mem_req_data   = is_empty ? '0 : data_q[head_q];
    assign mem_req_byteen = is_empty ? '0 : byteen_q[head_q];

    assign empty = is_empty;
    assign count = count_q;

    // Occupancy tracking: valid bits, pointers and count.
    // NOTE: sequential state uses non-blocking assignments so every reader
    // sees the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_deq) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    // Entry payload: allocate at the tail or byte-merge into a pending entry.
    // NOTE: payload storage has no reset; valid_q alone decides whether an
    // entry means anything, which keeps the wide arrays as plain flops/RAM.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_q[tail_q]   <= evict_addr;
            data_q[tail_q]   <= evict_data;
            byteen_q[tail_q] <= evict_byteen;
        end
        if (do_merge) begin
            for (int b = 0; b < LINE_SIZE; b++) begin
                if (evict_byteen[b]) begin
                    data_q[merge_idx][b*8 +: 8] <= evict_data[b*8 +: 8];
                end
            end
            byteen_q[merge_idx] <= byteen_q[merge_idx] | evict_byteen;
        end
    end

endmodule

// File: doc/vx_cache_evict_buffer.md
# vx_cache_evict_buffer

Write-back eviction buffer sitting directly downstream of the cache bank data store when `WRITEBACK` is enabled. It captures evicted lines (data plus per-byte dirty mask), drops clean lines, merges repeat evictions to the same line, and drains entries in FIFO order as masked line writes to the memory request port. It also answers a combinational address lookup so the bank can hold a fill whose line is still waiting to be written back.

## Interface
- `LINE_SIZE`, 16: line size in bytes; the data width is `LINE_SIZE*8`.
- `LINE_ADDR_WIDTH`, 26: line address width.
- `DEPTH`, 4: number of entries; a power of 2, at least 2.

- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-low reset; asserted when 0.
- `evict_valid`  input  1  eviction request.
- `evict_ready`  output  1  eviction accepted when high together with `evict_valid`.
- `evict_addr`  input  LINE_ADDR_WIDTH  evicted line address.
- `evict_data`  input  LINE_SIZE*8  evicted line data.
- `evict_byteen`  input  LINE_SIZE  dirty-byte mask of the evicted line.
- `mem_req_valid`  output  1  a write request is pending.
- `mem_req_ready`  input  1  memory accepts the request.
- `mem_req_addr`  output  LINE_ADDR_WIDTH  head entry address.
- `mem_req_data`  output  LINE_SIZE*8  head entry data.
- `mem_req_byteen`  output  LINE_SIZE  head entry byte mask.
- `lookup_addr`  input  LINE_ADDR_WIDTH  address probed by the bank fill path.
- `lookup_hit`  output  1  a valid entry holds `lookup_addr`.
- `empty`  output  1  no valid entries.
- `count`  output  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage is a circular buffer with head and tail pointers of width log2(DEPTH) that wrap modulo DEPTH. Each entry holds {valid, addr, data, byteen}.
- The enqueue handshake is `evict_valid & evict_ready`.
- **Clean drop:** an accepted eviction with `evict_byteen == 0` changes no state.
- **Merge:** `merge_hit` means some valid entry other than the head has addr equal to `evict_addr`.
  - On an accepted dirty eviction with `merge_hit`, that entry's data bytes are replaced where `evict_byteen[b]` is 1.
  - Its byteen becomes the OR of the old and new masks.
  - Count and pointers are unchanged.
  - The head is never a merge target, because it may be leaving in the same cycle.
- **Allocate:** an accepted dirty eviction without `merge_hit` writes the tail entry, and the tail pointer increments.
- `evict_ready = ~full | merge_hit | (evict_byteen == 0)`, where full means count equals DEPTH.
  - Allocation into a slot freed by a same-cycle dequeue is not allowed when full.
- **Dequeue:**
  - `mem_req_valid = ~empty`.
  - The `mem_req_*` outputs come from the head entry and are driven from registered state only.
  - While `mem_req_valid` is high and `mem_req_ready` is low, the outputs stay stable.
  - A merge never touches the head, so the presented data does not change while pending.
  - On `mem_req_valid & mem_req_ready`, the head is invalidated and the head pointer increments.
- **Simultaneous allocate and dequeue:** count is unchanged and both pointers advance. With count = 1 this leaves exactly the new entry.
- A new eviction whose address equals only the head allocates a second entry. FIFO order guarantees that the older write reaches memory first.
- `lookup_hit` is combinational: the OR over valid entries, including the head, of `addr == lookup_addr`. An eviction being accepted in the same cycle is not included.
- `count` and `empty` reflect registered state.

## Timing
- **Reset:** asserting `reset` low clears all valid bits, the pointers and count asynchronously. Any pending entries, including one mid-handshake, are discarded.
- **Outputs during reset and after release:** `mem_req_valid=0`, `empty=1`, `count=0`, `lookup_hit=0`, and `evict_ready=1`. `mem_req_addr`, `mem_req_data` and `mem_req_byteen` are 0.
- **Enqueue latency:** an eviction accepted at edge N into an empty buffer gives `mem_req_valid=1` in the cycle after edge N. It dequeues at the first edge where `mem_req_ready` is 1.
- **Merge latency:** a merge accepted at edge N is visible in the entry, and later at `mem_req_*` if it reaches the head, from the cycle after edge N.
- **Throughput:** one enqueue and one dequeue per cycle are sustained while not full.
- **Combinational paths:**
  - `evict_ready` depends combinationally on `evict_addr` and `evict_byteen`, but not on `mem_req_ready`.
  - There is no combinational path from any `evict_*` input to any `mem_req_*` output.

## Test plan
- **Basic pass:** after reset, evict A=0x10 with byteen=0x000F and data D1, with `mem_req_ready=1`. Required: one cycle later `mem_req_valid=1`, addr 0x10, byteen 0x000F, data D1; after the dequeue edge, `empty=1`.
- **Clean drop:** evict addr 0x20 with byteen=0. Required: `evict_ready=1`, `count` stays 0, and `mem_req_valid` never rises.
- **Merge:**
  - With `mem_req_ready=0`, evict 0x30 (byteen 0x00FF), then 0x40 (byteen 0x00F0, bytes 0xAA), then 0x40 again (byteen 0x0F00, bytes 0xBB).
  - Required: count=2.
  - Then raise ready. Required: 0x30 is issued first, then 0x40 with byteen 0x0FF0 carrying both 0xAA and 0xBB bytes.
- **Full/backpressure:**
  - With DEPTH=4 and `mem_req_ready=0`, fill 4 distinct dirty lines. Required: count=4 and `evict_ready=0` for a new address.
  - A fifth eviction to an existing non-head address is still accepted as a merge.
  - Raising `mem_req_ready` for one cycle gives count=3 and `evict_ready=1`.
- **Wrap and simultaneous:**
  - Stream 10 evictions with `mem_req_ready=1` every cycle. Required: count toggles between 0 and 1, and the issue order equals the enqueue order across pointer wrap.
  - `lookup_hit=1` for address 0x40 while it is resident, and 0 after it is dequeued.
- **Reset mid-operation:** pull `reset` low with 3 entries pending and `mem_req_valid=1`. Required: `mem_req_valid=0`, `count=0` and `lookup_hit=0` immediately, with no clock edge needed; after release, no stale request is issued.
